// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and state-load helper for the Trivium
// receive-side decryptor and its keystream core.
package trivium_pkg;

    localparam int TRIV_STATE_W     = 288;
    localparam int TRIV_KEY_W       = 80;
    localparam int TRIV_IV_W        = 80;
    localparam int TRIV_INIT_ROUNDS = 1152;
    localparam int TRIV_GEN_STEPS   = 8;
    localparam int TRIV_CNT_W       = 11;
    localparam int TRIV_GEN_CNT_W   = 3;

    // Tap positions as 0-based indices into st[], where st[k] holds s(k+1).
    localparam int TAP_S66  = 65;
    localparam int TAP_S69  = 68;
    localparam int TAP_S91  = 90;
    localparam int TAP_S92  = 91;
    localparam int TAP_S93  = 92;
    localparam int TAP_S162 = 161;
    localparam int TAP_S171 = 170;
    localparam int TAP_S175 = 174;
    localparam int TAP_S176 = 175;
    localparam int TAP_S177 = 176;
    localparam int TAP_S243 = 242;
    localparam int TAP_S264 = 263;
    localparam int TAP_S286 = 285;
    localparam int TAP_S287 = 286;
    localparam int TAP_S288 = 287;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        GEN   = 2'd2,
        READY = 2'd3
    } triv_fsm_e;

    // Build the initial 288-bit state from a key and an IV:
    // s1..s80 = key, s94..s173 = iv, s286..s288 = 1, everything else 0.
    function automatic logic [TRIV_STATE_W-1:0] triv_load_state(
        input logic [TRIV_KEY_W-1:0] key,
        input logic [TRIV_IV_W-1:0]  iv
    );
        logic [TRIV_STATE_W-1:0] st;
        st          = {TRIV_STATE_W{1'b0}};
        st[79:0]    = key;
        st[172:93]  = iv;
        st[287:285] = 3'b111;
        return st;
    endfunction

endpackage

// File: rtl/trivium_core.sv
// Trivium keystream core: holds the 288-bit state, loads it from key/IV and
// advances it one step when asked. z is combinational from the current state.
module trivium_core
    import trivium_pkg::*;
#(
    parameter logic [TRIV_KEY_W-1:0] RST_KEY    = 80'h0,
    parameter logic [TRIV_IV_W-1:0]  RST_IV     = 80'h0,
    parameter bit                    RST_LOADED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [TRIV_KEY_W-1:0] key,
    input  logic [TRIV_IV_W-1:0]  iv,
    output logic                  z
);

    // Reset either clears the state or pre-loads it for an auto-started warm-up.
    localparam logic [TRIV_STATE_W-1:0] RST_STATE =
        RST_LOADED ? triv_load_state(RST_KEY, RST_IV) : {TRIV_STATE_W{1'b0}};

    logic [TRIV_STATE_W-1:0] r_st;
    logic [TRIV_STATE_W-1:0] w_st_next;
    logic                    w_t1;
    logic                    w_t2;
    logic                    w_t3;
    logic                    w_t1_fb;
    logic                    w_t2_fb;
    logic                    w_t3_fb;

    assign w_t1 = r_st[TAP_S66]  ^ r_st[TAP_S93];
    assign w_t2 = r_st[TAP_S162] ^ r_st[TAP_S177];
    assign w_t3 = r_st[TAP_S243] ^ r_st[TAP_S288];

    assign z = w_t1 ^ w_t2 ^ w_t3;

    assign w_t1_fb = w_t1 ^ (r_st[TAP_S91]  & r_st[TAP_S92])  ^ r_st[TAP_S171];
    assign w_t2_fb = w_t2 ^ (r_st[TAP_S175] & r_st[TAP_S176]) ^ r_st[TAP_S264];
    assign w_t3_fb = w_t3 ^ (r_st[TAP_S286] & r_st[TAP_S287]) ^ r_st[TAP_S69];

    // Each register shifts towards higher indices; feedback enters at its head
    // (s1 gets t3', s94 gets t1', s178 gets t2').
    assign w_st_next = {r_st[286:177], w_t2_fb,
                        r_st[175:93],  w_t1_fb,
                        r_st[91:0],    w_t3_fb};

    // State register: load has priority over step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st <= RST_STATE;
        end else if (load) begin
            r_st <= triv_load_state(key, iv);
        end else if (step) begin
            r_st <= w_st_next;
        end
    end

endmodule

// File: rtl/trivium_rx_decrypt.sv
// Receive-side Trivium byte decryptor: accepts an IV, runs the 1152-step
// warm-up, stages one keystream byte at a time and XORs it onto incoming
// ciphertext bytes, presenting plaintext through a registered valid/ready port.
module trivium_rx_decrypt
    import trivium_pkg::*;
#(
    parameter logic [TRIV_KEY_W-1:0] KEY        = 80'h0,
    parameter bit                    AUTO_START = 1'b0,
    parameter logic [TRIV_IV_W-1:0]  IV_DEFAULT = 80'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_iv_valid,
    input  logic [TRIV_IV_W-1:0] i_iv_data,
    output logic                 o_iv_ready,
    input  logic                 i_in_valid,
    input  logic [7:0]           i_in_data,
    output logic                 o_in_ready,
    output logic                 o_out_valid,
    output logic [7:0]           o_out_data,
    input  logic                 i_out_ready,
    output logic                 o_ks_ready
);

    localparam logic [TRIV_CNT_W-1:0]     INIT_LAST = TRIV_CNT_W'(TRIV_INIT_ROUNDS - 1);
    localparam logic [TRIV_GEN_CNT_W-1:0] GEN_LAST  = TRIV_GEN_CNT_W'(TRIV_GEN_STEPS - 1);
    localparam triv_fsm_e                 RST_FSM   = AUTO_START ? INIT : IDLE;

    triv_fsm_e                 r_state;
    triv_fsm_e                 w_state_next;
    logic [TRIV_CNT_W-1:0]     r_init_cnt;
    logic [TRIV_GEN_CNT_W-1:0] r_gen_cnt;
    logic [7:0]                r_ks_byte;
    logic                      r_out_valid;
    logic [7:0]                r_out_data;

    logic                      w_iv_ready;
    logic                      w_ks_ready;
    logic                      w_step;
    logic                      w_in_ready;
    logic                      w_iv_fire;
    logic                      w_in_fire;
    logic                      w_z;

    trivium_core #(
        .RST_KEY    (KEY),
        .RST_IV     (IV_DEFAULT),
        .RST_LOADED (AUTO_START)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (w_iv_fire),
        .step (w_step),
        .key  (KEY),
        .iv   (i_iv_data),
        .z    (w_z)
    );

    // IV wins over ciphertext: a pending IV blocks in_ready in the same cycle.
    assign w_iv_fire  = i_iv_valid & w_iv_ready;
    assign w_in_ready = w_ks_ready & ~i_iv_valid & (~r_out_valid | i_out_ready);
    assign w_in_fire  = i_in_valid & w_in_ready;

    assign o_iv_ready  = w_iv_ready;
    assign o_ks_ready  = w_ks_ready;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_FSM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_iv_fire) w_state_next = INIT;
                else           w_state_next = IDLE;
            end
            INIT: begin
                if (r_init_cnt == INIT_LAST) w_state_next = GEN;
                else                         w_state_next = INIT;
            end
            GEN: begin
                if (r_gen_cnt == GEN_LAST) w_state_next = READY;
                else                       w_state_next = GEN;
            end
            READY: begin
                if (w_iv_fire)      w_state_next = INIT;
                else if (w_in_fire) w_state_next = GEN;
                else                w_state_next = READY;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and core stepping per state.
    always_comb begin
        w_iv_ready = 1'b0;
        w_ks_ready = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            IDLE:    w_iv_ready = 1'b1;
            INIT:    w_step     = 1'b1;
            GEN:     w_step     = 1'b1;
            READY: begin
                w_iv_ready = 1'b1;
                w_ks_ready = 1'b1;
            end
            default: w_step = 1'b0;
        endcase
    end

    // Warm-up step counter: runs only in INIT, restarts for every new IV.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init_cnt <= {TRIV_CNT_W{1'b0}};
        end else if (r_state == INIT && r_init_cnt != INIT_LAST) begin
            r_init_cnt <= r_init_cnt + {{(TRIV_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_init_cnt <= {TRIV_CNT_W{1'b0}};
        end
    end

    // Keystream bit counter: runs only in GEN, wraps to 0 after the eighth bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gen_cnt <= {TRIV_GEN_CNT_W{1'b0}};
        end else if (r_state == GEN) begin
            r_gen_cnt <= r_gen_cnt + {{(TRIV_GEN_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_gen_cnt <= {TRIV_GEN_CNT_W{1'b0}};
        end
    end

    // Staged keystream byte: z of GEN step j lands in bit j (LSB first).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ks_byte <= 8'h00;
        end else if (r_state == GEN) begin
            r_ks_byte[r_gen_cnt] <= w_z;
        end
    end

    // Plaintext register: reload on accept, clear on sink take, hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_in_data ^ r_ks_byte;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trivium_rx_decrypt.sv
// Directed/randomised bench for trivium_rx_decrypt with a bit-level Trivium
// reference model written directly from s1..s288 indexing.
module tb_trivium_rx_decrypt;

    localparam logic [79:0] H_KEY = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] H_IV  = 80'hECBB76B09AFF71D0D151;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    // main DUT (key H_KEY, manual start)
    logic        i_iv_valid = 1'b0;
    logic [79:0] i_iv_data  = 80'h0;
    logic        o_iv_ready;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data  = 8'h00;
    logic        o_in_ready;
    logic        o_out_valid;
    logic [7:0]  o_out_data;
    logic        i_out_ready = 1'b1;
    logic        o_ks_ready;

    // second DUT (key 0, auto start with IV 0)
    logic        a_iv_valid = 1'b0;
    logic [79:0] a_iv_data  = 80'h0;
    logic        a_iv_ready;
    logic        a_in_valid = 1'b0;
    logic [7:0]  a_in_data  = 8'h00;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic        a_out_ready = 1'b1;
    logic        a_ks_ready;

    trivium_rx_decrypt #(.KEY(H_KEY), .AUTO_START(1'b0), .IV_DEFAULT(80'h0)) dut (
        .clk(clk), .rst(rst),
        .i_iv_valid(i_iv_valid), .i_iv_data(i_iv_data), .o_iv_ready(o_iv_ready),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
        .o_ks_ready(o_ks_ready)
    );

    trivium_rx_decrypt #(.KEY(80'h0), .AUTO_START(1'b1), .IV_DEFAULT(80'h0)) dut0 (
        .clk(clk), .rst(rst),
        .i_iv_valid(a_iv_valid), .i_iv_data(a_iv_data), .o_iv_ready(a_iv_ready),
        .i_in_valid(a_in_valid), .i_in_data(a_in_data), .o_in_ready(a_in_ready),
        .o_out_valid(a_out_valid), .o_out_data(a_out_data), .i_out_ready(a_out_ready),
        .o_ks_ready(a_ks_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];

    // cycle counter used to measure handshake spacing
    always @(posedge clk) cyc <= cyc + 1;

    // sink monitor: every byte the main DUT hands over
    always @(posedge clk) begin
        if (o_out_valid && i_out_ready) rx_q.push_back(o_out_data);
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    bit         ms  [1:288];
    logic [7:0] mks [0:7];

    function automatic void m_load(input logic [79:0] k, input logic [79:0] iv);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = iv[i-1];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    endfunction

    function automatic bit m_step();
        bit t1, t2, t3, z, n1, n2, n3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        n1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        n2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        n3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = n2;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = n1;
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = n3;
        return z;
    endfunction

    // first 8 keystream bytes after warm-up, bits LSB first
    task automatic m_keystream(input logic [79:0] k, input logic [79:0] iv);
        bit z;
        m_load(k, iv);
        for (int i = 0; i < 1152; i++) z = m_step();
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 8; j++) mks[b][j] = m_step();
        end
    endtask

    // ---------------- helpers ----------------
    int last_hs = 0;

    task automatic send_byte(input string tag, input logic [7:0] c, input logic [7:0] expv,
                             input bit push, input bit chk_gap);
        int n = 0;
        i_in_valid = 1'b1;
        i_in_data  = c;
        #1;
        while (!o_in_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_rdy"}, o_in_ready, 1);
        if (chk_gap) check({tag, "_gap"}, cyc + 1 - last_hs, 9);
        last_hs = cyc + 1;
        @(negedge clk);
        i_in_valid = 1'b0;
        check({tag, "_ov"}, o_out_valid, 1);
        check({tag, "_od"}, o_out_data, expv);
        if (push) exp_q.push_back(expv);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_ks_ready && n < 2000) begin
            @(negedge clk); n++;
        end
        check(tag, o_ks_ready, 1);
    endtask

    logic [7:0] ksa [0:7];
    logic [7:0] ks0 [0:7];
    logic [7:0] ksh [0:7];
    logic [7:0] cb  [0:5];
    logic [7:0] hello [0:4];

    initial begin
        int n;
        int a_last;
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        m_keystream(H_KEY, 80'h0); ksa = mks;
        m_keystream(80'h0, 80'h0); ks0 = mks;
        m_keystream(H_KEY, H_IV);  ksh = mks;
        for (int i = 0; i < 6; i++) cb[i] = 8'($urandom);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_out_data",  o_out_data,  0);
        check("rst_in_ready",  o_in_ready,  0);
        check("rst_ks_ready",  o_ks_ready,  0);
        check("rst_iv_ready",  o_iv_ready,  1);
        check("rst_auto_iv_ready", a_iv_ready, 0);
        rst = 1'b1;

        // ---- auto-start DUT: warm-up timing and key-0 keystream ----
        repeat (1159) @(negedge clk);
        check("auto_ks_early", a_ks_ready, 0);
        check("auto_in_early", a_in_ready, 0);
        @(negedge clk);
        check("auto_ks_on", a_ks_ready, 1);
        a_last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            a_in_valid = 1'b1; a_in_data = 8'h00;
            #1;
            while (!a_in_ready && n < 40) begin
                @(negedge clk); #1; n++;
            end
            check("auto_rdy", a_in_ready, 1);
            if (k > 0) check("auto_gap", cyc + 1 - a_last, 9);
            a_last = cyc + 1;
            @(negedge clk);
            a_in_valid = 1'b0;
            check("auto_ks_byte", a_out_data, ks0[k]);
        end

        // ---- main DUT idles with iv_valid low ----
        repeat (2000 - 1200) @(negedge clk);
        check("idle_iv_ready", o_iv_ready,  1);
        check("idle_ks_ready", o_ks_ready,  0);
        check("idle_in_ready", o_in_ready,  0);
        check("idle_out_valid", o_out_valid, 0);

        // ---- IV handshake and warm-up timing ----
        i_iv_valid = 1'b1; i_iv_data = 80'h0;
        #1;
        check("iv_ready_idle", o_iv_ready, 1);
        @(negedge clk);
        i_iv_valid = 1'b0;
        repeat (500) @(negedge clk);
        i_iv_valid = 1'b1; i_iv_data = {16'($urandom), $urandom, $urandom};
        #1;
        check("iv_ready_init", o_iv_ready, 0);
        @(negedge clk);
        i_iv_valid = 1'b0;
        repeat (658) @(negedge clk);
        check("warm_in_low",  o_in_ready, 0);
        check("warm_ks_low",  o_ks_ready, 0);
        @(negedge clk);
        check("warm_in_high", o_in_ready, 1);
        check("warm_ks_high", o_ks_ready, 1);

        // ---- random ciphertext, free-flowing sink ----
        for (int k = 0; k < 4; k++) send_byte("stream", cb[k], cb[k] ^ ksa[k], 1'b1, k > 0);

        // ---- sink stall for 50 cycles with a byte waiting ----
        @(negedge clk);
        i_out_ready = 1'b0;
        send_byte("stall_first", cb[4], cb[4] ^ ksa[4], 1'b1, 1'b0);
        i_in_valid = 1'b1; i_in_data = cb[5];
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            check("stall_in_ready", o_in_ready, 0);
            check("stall_out_data", o_out_data, cb[4] ^ ksa[4]);
        end
        i_out_ready = 1'b1;
        #1;
        check("release_in_ready", o_in_ready, 1);
        @(negedge clk);
        i_in_valid = 1'b0;
        check("release_od", o_out_data, cb[5] ^ ksa[5]);
        exp_q.push_back(cb[5] ^ ksa[5]);
        i_out_ready = 1'b0;

        // ---- rekey with ciphertext offered together; pending byte kept ----
        wait_ready("rekey_wait");
        i_iv_valid = 1'b1; i_iv_data = H_IV;
        i_in_valid = 1'b1; i_in_data = 8'($urandom);
        #1;
        check("prio_in_ready", o_in_ready, 0);
        check("prio_iv_ready", o_iv_ready, 1);
        @(negedge clk);
        i_iv_valid = 1'b0; i_in_valid = 1'b0;
        check("rekey_keep_ov", o_out_valid, 1);
        check("rekey_keep_od", o_out_data, cb[5] ^ ksa[5]);
        check("rekey_ks_low",  o_ks_ready, 0);
        i_out_ready = 1'b1;
        repeat (1159) @(negedge clk);
        check("rekey_in_low",  o_in_ready, 0);
        @(negedge clk);
        check("rekey_in_high", o_in_ready, 1);

        // ---- HELLO under the new IV ----
        for (int k = 0; k < 5; k++) send_byte("hello", hello[k] ^ ksh[k], hello[k], 1'b1, k > 0);
        @(negedge clk);
        i_out_ready = 1'b0;

        // ---- reset asserted mid-INIT with a byte pending ----
        send_byte("pend", cb[0], cb[0] ^ ksh[5], 1'b0, 1'b1);
        wait_ready("pend_wait");
        i_iv_valid = 1'b1; i_iv_data = {16'($urandom), $urandom, $urandom};
        @(negedge clk);
        i_iv_valid = 1'b0;
        repeat (300) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", o_out_valid, 0);
        check("arst_out_data",  o_out_data,  0);
        check("arst_iv_ready",  o_iv_ready,  1);
        check("arst_ks_ready",  o_ks_ready,  0);
        check("arst_auto_iv",   a_iv_ready,  0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        i_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("post_iv_ready", o_iv_ready, 1);
        check("post_in_ready", o_in_ready, 0);

        // ---- no byte lost or duplicated at the sink ----
        check("sink_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("sink_byte", rx_q[i], exp_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trivium_rx_decrypt.md
Name: trivium_rx_decrypt

Overview:
- Receive-side byte decryptor for the team's Trivium link.
- Accepts an 80-bit IV from the link, runs the Trivium 1152-round warm-up, then XORs incoming ciphertext bytes with generated keystream bytes and emits plaintext over a valid/ready interface.
- Sits between the link deframer (ciphertext in) and the application sink (plaintext out).
- Contains its own keystream core.

Parameters:
- KEY, 80'h0, 80-bit secret key; K_i = KEY[i-1].
- AUTO_START, 0: if 1, leave reset directly into INIT using IV_DEFAULT.
- IV_DEFAULT, 80'h0, IV used when AUTO_START=1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- iv_valid  input  1  new IV offered
- iv_data  input  80  IV; IV_i = iv_data[i-1]
- iv_ready  output  1  IV can be accepted
- in_valid  input  1  ciphertext byte valid
- in_data  input  8  ciphertext byte
- in_ready  output  1  ciphertext byte accepted this cycle if in_valid
- out_valid  output  1  plaintext byte valid
- out_data  output  8  plaintext byte
- out_ready  input  1  sink accepts plaintext
- ks_ready  output  1  warm-up done; keystream byte staged

Behaviour:
- Trivium state st[0..287], with st[k] = s(k+1).
- Load:
  - s1..s80 = K1..K80.
  - s94..s173 = IV1..IV80.
  - s286..s288 = 1.
  - All other bits 0.
- Step, all terms from the current state:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288.
  - z = t1^t2^t3.
  - t1' = t1^(s91&s92)^s171.
  - t2' = t2^(s175&s176)^s264.
  - t3' = t3^(s286&s287)^s69.
  - Shift: s1..s93 <= {t3', s1..s92}; s94..s177 <= {t1', s94..s176}; s178..s288 <= {t2', s178..s287}.
- FSM states:
  - IDLE: iv_ready=1. An IV handshake loads the state and goes to INIT.
  - INIT: 1152 steps, z discarded, 11-bit counter, then GEN.
  - GEN: 8 steps. The z of step j goes to ks_byte[j] (LSB first). Then READY.
  - READY: ks_ready=1, iv_ready=1.
- Ciphertext handshake:
  - in_ready = (state==READY) && !iv_valid && (!out_valid || out_ready).
  - On in_valid && in_ready: out_data <= in_data ^ ks_byte, out_valid <= 1, state -> GEN.
- Latency and throughput: input handshake at edge N gives out_valid high after edge N. Sustained rate is one byte per 9 cycles.
- Output register: out_valid clears on out_valid && out_ready unless reloaded in the same edge. out_data is held stable while out_valid && !out_ready.
- Rekey:
  - An IV handshake in READY discards the staged keystream byte, reloads, and goes to INIT. IV has priority over ciphertext in the same cycle.
  - A pending out_valid byte is retained across rekey.
  - iv_ready=0 in INIT and GEN; iv_valid is ignored there.
- Warm-up timing: in_ready can first rise exactly 1160 edges after the IV-load edge (1152 INIT + 8 GEN).
- Reset:
  - Asserting rst at any time, including mid-INIT or mid-GEN, aborts immediately.
  - Reset values: out_valid=0, out_data=0, ks_ready=0, in_ready=0, counters=0.
  - With AUTO_START=0: state IDLE, iv_ready=1.
  - With AUTO_START=1: state loaded from KEY/IV_DEFAULT, state INIT, iv_ready=0.

Decomposition:
- Package trivium_pkg:
  - TRIV_STATE_W=288, TRIV_KEY_W=80, TRIV_IV_W=80, TRIV_INIT_ROUNDS=1152.
  - Tap index constants.
  - FSM state enum {IDLE, INIT, GEN, READY}.
- Sub-module trivium_core:
  - Ports: clk, rst, load, step, key, iv, z.
  - Holds the 288-bit state; z is combinational from the current state.
- trivium_rx_decrypt holds the FSM, counters, ks_byte, handshakes and output register.

Test Plan:
- Reset with AUTO_START=0 -> out_valid=0, in_ready=0, ks_ready=0, iv_ready=1. No state change while iv_valid=0 for 2000 cycles.
- KEY=0, IV handshake iv_data=0 at edge E -> in_ready low through edge E+1159 and high after edge E+1160. ks_byte equals the golden-model first 8 z bits, LSB first.
- Ciphertext 0x00 x4, out_ready=1 -> out_data equals golden keystream bytes 0..3. Handshakes are spaced 9 cycles apart.
- Golden model encrypts "HELLO" (KEY=80'h9719CFC92A9FF688F9AA, IV=80'hECBB76B09AFF71D0D151) -> outputs 0x48 0x45 0x4C 0x4C 0x4F.
- out_ready=0 for 50 cycles with in_valid=1 -> out_data stable, in_ready=0. After release the next byte decrypts correctly; no byte is lost or duplicated.
- iv_valid and in_valid both high in READY -> IV accepted, byte not accepted. After 1160 edges the output matches the new-IV stream. Reset asserted mid-INIT -> IDLE, out_valid=0 asynchronously.
